memory_stage: RTL
=================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have ports, one per line (name, direction, width, meaning); clock and reset come first.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 EX_valid  in  1  execute register holds a valid instruction.
REQ-005 EX_alu_result, EX_rs2_data, EX_ir, EX_PC_4  in  32 each  address/result, store data, instruction, PC+4.
REQ-006 EX_rf_wr_sel  in  2 / EX_regWrite, EX_memRead, EX_memWrite, EX_sign  in  1 / EX_size  in  2 (0=byte, 1=half, 2=word).
REQ-007 dmem_req, dmem_we  out  1 / dmem_addr, dmem_wdata  out  32 / dmem_be  out  4  data-memory request.
REQ-008 dmem_ack  in  1 / dmem_rdata  in  32  data-memory completion and word-aligned read data.
REQ-009 MR_dout2, MR_alu_result, MR_ir, MR_PC_4  out  32 / MR_rf_wr_sel  out  2 / MR_regWrite, MR_valid  out  1  to writeback.
REQ-010 stall  out  1  holds execute register and earlier stages.
REQ-011 misalign_err  out  1  one-cycle pulse on misaligned access.

Function
REQ-012 FSM states SHALL be IDLE and WAIT.
REQ-013 Non-memory instruction (EX_valid, not memRead/memWrite) in IDLE: MR_* SHALL load EX_* at next edge; latency 1; MR_dout2=0.
REQ-014 Memory instruction in IDLE, aligned: dmem_req SHALL assert combinationally that cycle, go to WAIT, stall=1.
REQ-015 In WAIT: dmem_req, dmem_addr, dmem_we, dmem_wdata, dmem_be SHALL be held stable until dmem_ack=1.
REQ-016 dmem_ack in IDLE-request cycle or WAIT SHALL complete access; MR_* loads at that edge; FSM to IDLE; stall deasserts in the same cycle.
REQ-017 stall SHALL equal (memory op pending and not dmem_ack).
REQ-018 MR_valid SHALL be 0 in every cycle after an edge with no completed instruction (bubble); MR_regWrite SHALL be 0 whenever MR_valid=0.
REQ-019 dmem_addr SHALL equal {EX_alu_result[31:2],2'b00}.
REQ-020 Byte enables: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
REQ-021 Store data SHALL be replicated: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
REQ-022 Load data SHALL select the addressed byte/half from dmem_rdata; EX_sign=1 sign-extends, 0 zero-extends; result to MR_dout2.
REQ-023 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no dmem_req; misalign_err pulses; MR_valid=1 with MR_regWrite=0; latency 1.
REQ-024 Store completion SHALL produce MR_dout2=0 and MR_regWrite=EX_regWrite (0 for legal stores).
REQ-025 EX_valid=0 in IDLE SHALL produce a bubble and no request.
REQ-026 memRead and memWrite both asserted SHALL be treated as a store.

Reset
REQ-027 RST=1 SHALL force IDLE, all MR_* outputs 0, MR_valid=0, misalign_err=0 immediately, without waiting for CLK.
REQ-028 dmem_req, stall SHALL be 0 while RST=1; a pending access is abandoned and a late dmem_ack after reset SHALL be ignored.

Structure
REQ-029 Shared package otter_pkg SHALL hold mem_size_t (BYTE, HALF, WORD), the FSM state enum and the rf_wr_sel encodings.
REQ-030 Load alignment/extension SHALL be a combinational sub-module load_align.
REQ-031 Store byte-enable/replication logic SHALL stay inline.

Verification
REQ-032 ALU op, alu_result=0x0000_1234, regWrite=1 -> next edge MR_alu_result=0x1234, MR_valid=1, no dmem_req.
REQ-033 lb addr 0x103, rdata 0x80_00_00_00, ack after 3 cycles, sign=1 -> stall 3 cycles, MR_dout2=0xFFFF_FF80.
REQ-034 sh rs2=0xABCD_1234 addr 0x202, ack same cycle -> dmem_be=4'b1100, wdata=0x1234_1234, addr=0x200, no stall.
REQ-035 lw addr 0x101 -> misalign_err pulse, no dmem_req, MR_regWrite=0.
REQ-036 RST asserted in WAIT, then ack arrives -> state IDLE, MR_valid=0, ack ignored.
REQ-037 Back-to-back lw/lw, ack delays 0 and 2 cycles -> dmem_req held both, two MR_valid pulses, order preserved.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared types for the OTTER memory stage: access sizes, FSM states and
// register-file write-select encodings.
package otter_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] RF_SEL_PC4 = 2'd0;
  localparam logic [1:0] RF_SEL_CSR = 2'd1;
  localparam logic [1:0] RF_SEL_MEM = 2'd2;
  localparam logic [1:0] RF_SEL_ALU = 2'd3;

  // Any size outside BYTE/HALF behaves as a word access.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a word-aligned read and extends it
// to 32 bits (sign or zero).
module load_align
  import otter_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = rdata_i;
    case (mem_size_t'(size_i))
      BYTE:    data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      HALF:    data_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues data-memory requests, stalls earlier stages
// until the access is acknowledged and hands results to writeback.
module memory_stage
  import otter_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        EX_valid,
  input  logic [31:0] EX_alu_result,
  input  logic [31:0] EX_rs2_data,
  input  logic [31:0] EX_ir,
  input  logic [31:0] EX_PC_4,
  input  logic [1:0]  EX_rf_wr_sel,
  input  logic        EX_regWrite,
  input  logic        EX_memRead,
  input  logic        EX_memWrite,
  input  logic        EX_sign,
  input  logic [1:0]  EX_size,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MR_dout2,
  output logic [31:0] MR_alu_result,
  output logic [31:0] MR_ir,
  output logic [31:0] MR_PC_4,
  output logic [1:0]  MR_rf_wr_sel,
  output logic        MR_regWrite,
  output logic        MR_valid,
  output logic        stall,
  output logic        misalign_err
);

  mem_state_t  state_q, state_d;
  mem_size_t   ex_size;
  logic        mem_op, misaligned, in_wait, issue;
  logic        complete_mem, complete_other, done;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q, sign_q;
  logic [1:0]  size_q, off_q;

  logic        cur_we, cur_sign;
  logic [1:0]  cur_size, cur_off;
  logic [31:0] load_data;

  logic [31:0] mr_dout2_q, mr_alu_result_q, mr_ir_q, mr_pc_4_q;
  logic [1:0]  mr_rf_wr_sel_q;
  logic        mr_regwrite_q, mr_valid_q, misalign_q;

  assign ex_size    = mem_size_t'(EX_size);
  assign mem_op     = EX_memRead | EX_memWrite;
  assign misaligned = is_misaligned(ex_size, EX_alu_result[1:0]);
  assign in_wait    = (state_q == WAIT);
  assign issue      = !in_wait && EX_valid && mem_op && !misaligned;

  assign dmem_req       = !RST && (issue || in_wait);
  assign stall          = dmem_req && !dmem_ack;
  assign complete_mem   = dmem_req && dmem_ack;
  assign complete_other = !in_wait && EX_valid && (!mem_op || misaligned);
  assign done           = complete_mem || complete_other;

  // Per-lane store enables and replicated store data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = gi;
    assign be_new[gi] = (ex_size == BYTE) ? (EX_alu_result[1:0] == LANE) :
                        (ex_size == HALF) ? (EX_alu_result[1] == LANE[1]) : 1'b1;
    assign wdata_new[gi*8 +: 8] = (ex_size == BYTE) ? EX_rs2_data[7:0] :
                                  (ex_size == HALF) ? EX_rs2_data[(gi%2)*8 +: 8] :
                                                      EX_rs2_data[gi*8 +: 8];
  end

  // While waiting the request is replayed from its captured copy.
  assign dmem_we    = in_wait ? we_q : EX_memWrite;
  assign dmem_addr  = in_wait ? {addr_q, 2'b00} : {EX_alu_result[31:2], 2'b00};
  assign dmem_wdata = in_wait ? wdata_q : wdata_new;
  assign dmem_be    = in_wait ? be_q : be_new;

  assign cur_we   = dmem_we;
  assign cur_sign = in_wait ? sign_q : EX_sign;
  assign cur_size = in_wait ? size_q : EX_size;
  assign cur_off  = in_wait ? off_q : EX_alu_result[1:0];

  load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .offset_i (cur_off),
    .size_i   (cur_size),
    .sign_i   (cur_sign),
    .data_o   (load_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue && !dmem_ack) state_d = WAIT;
      WAIT:    if (dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        addr_q  <= EX_alu_result[31:2];
        wdata_q <= wdata_new;
        be_q    <= be_new;
        we_q    <= EX_memWrite;
        sign_q  <= EX_sign;
        size_q  <= EX_size;
        off_q   <= EX_alu_result[1:0];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mr_dout2_q      <= '0;
      mr_alu_result_q <= '0;
      mr_ir_q         <= '0;
      mr_pc_4_q       <= '0;
      mr_rf_wr_sel_q  <= '0;
      mr_regwrite_q   <= 1'b0;
      mr_valid_q      <= 1'b0;
      misalign_q      <= 1'b0;
    end else if (done) begin
      mr_valid_q      <= 1'b1;
      mr_alu_result_q <= EX_alu_result;
      mr_ir_q         <= EX_ir;
      mr_pc_4_q       <= EX_PC_4;
      mr_rf_wr_sel_q  <= EX_rf_wr_sel;
      // A misaligned memory op retires without touching the register file.
      mr_regwrite_q   <= complete_mem ? EX_regWrite : (EX_regWrite && !mem_op);
      mr_dout2_q      <= (complete_mem && !cur_we) ? load_data : 32'h0;
      misalign_q      <= complete_other && mem_op;
    end else begin
      mr_valid_q    <= 1'b0;
      mr_regwrite_q <= 1'b0;
      misalign_q    <= 1'b0;
    end
  end

  assign MR_dout2      = mr_dout2_q;
  assign MR_alu_result = mr_alu_result_q;
  assign MR_ir         = mr_ir_q;
  assign MR_PC_4       = mr_pc_4_q;
  assign MR_rf_wr_sel  = mr_rf_wr_sel_q;
  assign MR_regWrite   = mr_regwrite_q;
  assign MR_valid      = mr_valid_q;
  assign misalign_err  = misalign_q;

endmodule
